// File: rtl/gray_window_3x3.sv
// rtl/gray_window_3x3.sv - streaming 3x3 grayscale neighbourhood generator with two line buffers
// Optional end-of-frame pulse output enabled by GRAY_WINDOW_FRAME_DONE_EN.

module gray_window_3x3 #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  grayscale_i,
  input  logic        done_i,
  output logic [71:0] window_o,
`ifdef GRAY_WINDOW_FRAME_DONE_EN
  output logic        frame_done_o,
`endif
  output logic        done_o
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [71:0]   win_q, win_d;
  logic          done_q, done_d;

  // Line buffers are deliberately not reset; the valid rule masks stale rows.
  logic [7:0] lb_old_q [IMG_WIDTH];
  logic [7:0] lb_new_q [IMG_WIDTH];
  logic [7:0] old_px;
  logic [7:0] new_px;

  assign old_px = lb_old_q[col_q];
  assign new_px = lb_new_q[col_q];

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (done_i) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_comb begin
    win_d = win_q;
    if (done_i) begin
      for (int r = 0; r < 3; r++) begin
        win_d[8*(3*r)   +: 8] = win_q[8*(3*r+1) +: 8];
        win_d[8*(3*r+1) +: 8] = win_q[8*(3*r+2) +: 8];
      end
      win_d[8*2 +: 8] = old_px;
      win_d[8*5 +: 8] = new_px;
      win_d[8*8 +: 8] = grayscale_i;
    end
  end

  assign done_d = done_i && (row_q >= RW'(2)) && (col_q >= CW'(2));

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      win_q  <= '0;
      done_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      win_q  <= win_d;
      done_q <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (done_i) begin
      lb_old_q[col_q] <= new_px;
      lb_new_q[col_q] <= grayscale_i;
    end
  end

  assign window_o = win_q;
  assign done_o   = done_q;

`ifdef GRAY_WINDOW_FRAME_DONE_EN
  logic frame_done_q, frame_done_d;

  assign frame_done_d = done_i && (row_q == ROW_LAST) && (col_q == COL_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= frame_done_d;
    end
  end

  assign frame_done_o = frame_done_q;
`endif

endmodule

// File: doc/gray_window_3x3.md
# gray_window_3x3

Streaming 3x3 neighbourhood generator that sits directly downstream of `rgb_to_grayscale` and directly upstream of the Sobel kernel. It accepts one 8-bit grayscale pixel per `done_i` strobe in raster order. It keeps the two previous image rows in on-chip line buffers. For every pixel whose full 3x3 neighbourhood lies inside the frame, it presents that neighbourhood on a flat 72-bit bus with a one-cycle `done_o` qualifier.

## Interface
- `IMG_WIDTH`, default 512: pixels per row; must be ≥ 3.
- `IMG_HEIGHT`, default 512: rows per frame; must be ≥ 3.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `grayscale_i`  in  8  pixel value; sampled only when `done_i`=1.
- `done_i`  in  1  pixel-valid strobe, same meaning as the upstream `done_o`.
- `window_o`  out  72  3x3 window; `window_o[8*(3*r+c) +: 8]` = p[r][c].
  - r=0 is the oldest row (top); c=0 is the oldest column (left).
- `done_o`  out  1  `window_o` valid for this cycle only.
- `frame_done_o`  out  1  end-of-frame pulse; present only with `FRAME_DONE_EN`.

## Operation
- Counters:
  - `col` has width $clog2(IMG_WIDTH); `row` has width $clog2(IMG_HEIGHT).
  - Both advance only on accepted pixels (`done_i`=1).
  - `col` wraps from IMG_WIDTH-1 to 0 and increments `row`.
  - `row` wraps from IMG_HEIGHT-1 to 0, which starts a new frame.
- Line buffers:
  - Two memories of IMG_WIDTH x 8 each: `lb_old` holds row-2 and `lb_new` holds row-1.
  - On an accepted pixel at `col`:
    - read `lb_old[col]`, `lb_new[col]` and `grayscale_i`;
    - write `lb_old[col]` ← `lb_new[col]` and `lb_new[col]` ← `grayscale_i`.
  - This is read-before-write within the same cycle. It must be implementable as a register array or as a single-port RAM with asynchronous read.
- Window shift:
  - On an accepted pixel, columns shift left: p[r][0] ← p[r][1] and p[r][1] ← p[r][2].
  - New column: p[0][2] ← `lb_old[col]`, p[1][2] ← `lb_new[col]`, p[2][2] ← `grayscale_i`.
- Valid rule:
  - `done_o` ← `done_i` & (`row` ≥ 2) & (`col` ≥ 2), evaluated on the pre-increment counters.
  - The window centre is pixel (row-1, col-1).
  - Windows that straddle a row boundary (col 0,1) or include stale rows (row 0,1) are never flagged valid.
  - Each frame yields exactly (IMG_HEIGHT-2)·(IMG_WIDTH-2) valid windows.
- Line buffer contents are not reset; stale data is masked by the valid rule.
- No backpressure exists: the block accepts a pixel every cycle `done_i` is high.

## Timing
- Latency: the window containing pixel N appears with `done_o`=1 one cycle after `done_i` accepted pixel N (registered output).
- `done_i` gaps: counters, line buffers and window hold their values. `done_o`=0 in the cycle after any `done_i`=0, and `window_o` holds its last value.
- Reset values:
  - `row`=0, `col`=0;
  - `window_o`=72'h0, `done_o`=0, `frame_done_o`=0.
- Reset mid-frame: takes effect at the next edge. The next accepted pixel is treated as (0,0), and no valid window is produced until row 2, col 2 of the restarted frame.
- Back-to-back frames: the first pixel of frame k+1 may follow the last pixel of frame k on the next cycle. The row wrap guarantees no cross-frame window is flagged.

## Configuration
- Macro `GRAY_WINDOW_FRAME_DONE_EN` controls the end-of-frame output.
- Defined:
  - port `frame_done_o` exists;
  - it pulses 1 for exactly one cycle, in the same cycle as `done_o` for the last window of the frame, i.e. one cycle after accepting pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
All scenarios use IMG_WIDTH=4 and IMG_HEIGHT=4, with pixel (r,c) = 4r+c (values 0..15), fed continuously one per cycle starting after reset release.
- Basic stream:
  - first `done_o` occurs one cycle after pixel 10, with window = {0,1,2,4,5,6,8,9,10} (p00..p22);
  - the last window is {5,6,7,9,10,11,13,14,15};
  - exactly 4 `done_o` pulses occur per frame.
- Gapped input: insert a `done_i`=0 cycle after every pixel → same 4 windows with identical contents; `done_o` is never high two cycles in a row; `window_o` is stable during gaps.
- Back-to-back frames: send frame 2 with pixel value = 100+4r+c immediately after frame 1 → frame 2's first window is {100,101,102,104,105,106,108,109,110}; no pulses occur between pixels 0..9 of frame 2.
- Reset mid-frame: assert `rst` for one cycle after pixel 6, then restart the frame → all outputs are 0 the cycle after reset; the first `done_o` follows the new pixel 10 with the clean window {0,1,2,4,5,6,8,9,10}.
- `GRAY_WINDOW_FRAME_DONE_EN` defined → `frame_done_o` is high for exactly one cycle, coincident with the 4th `done_o` (window {5,6,7,9,10,11,13,14,15}), and 0 at all other times including after reset.
